change_dispenser: RTL and testbench

//  Pays out a change amount as physical coins, the payout end of the coin path.
//  It takes an 8-bit amount (cents) plus a start pulse from the vending FSM.
//  It drives a 4-phase req/ack handshake to the coin hopper, one coin at a time.

---
 rtl/vend_pkg.sv | 26 ++
 rtl/change_coin_select.sv | 31 +++
 rtl/change_dispenser.sv | 151 +++++++++++++++
 tb/tb_change_dispenser.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared vending-machine definitions: coin values, coin one-hot encoding and
// change-dispenser FSM states. Imported by the vending FSM and the change path.
package vend_pkg;

    localparam int unsigned COIN_5  = 5;
    localparam int unsigned COIN_10 = 10;
    localparam int unsigned COIN_25 = 25;

    // One-hot hopper request, bit order {25c,10c,5c}.
    typedef enum logic [2:0] {
        COIN_NONE   = 3'b000,
        COIN_SEL_5  = 3'b001,
        COIN_SEL_10 = 3'b010,
        COIN_SEL_25 = 3'b100
    } coin_sel_t;

    typedef enum logic [2:0] {
        CHG_IDLE,
        CHG_SELECT,
        CHG_REQUEST,
        CHG_RELEASE,
        CHG_DONE,
        CHG_FAULT
    } change_state_t;

endpackage

// File: rtl/change_coin_select.sv
// Combinational greedy coin picker: largest available coin not exceeding the
// remaining amount, or COIN_NONE when nothing fits.
module change_coin_select
    import vend_pkg::*;
#(
    parameter int AMT_W = 8
) (
    input  logic [AMT_W-1:0] remaining,
    input  logic [2:0]       avail,
    output coin_sel_t        sel,
    output logic [AMT_W-1:0] value
);

    // NOTE: every output gets a default before the priority chain so no path
    // leaves a value unassigned, which would otherwise infer a latch.
    always_comb begin
        sel   = COIN_NONE;
        value = '0;
        if (avail[2] && (remaining >= AMT_W'(COIN_25))) begin
            sel   = COIN_SEL_25;
            value = AMT_W'(COIN_25);
        end else if (avail[1] && (remaining >= AMT_W'(COIN_10))) begin
            sel   = COIN_SEL_10;
            value = AMT_W'(COIN_10);
        end else if (avail[0] && (remaining >= AMT_W'(COIN_5))) begin
            sel   = COIN_SEL_5;
            value = AMT_W'(COIN_5);
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Change payout controller: greedy coin selection, 4-phase req/ack to the hopper,
// ack timeout fault. Per-denomination inventory is kept when CHANGE_INVENTORY_EN is defined.
module change_dispenser
    import vend_pkg::*;
#(
    parameter int AMT_W       = 8,
    parameter int ACK_TIMEOUT = 255,
    parameter int INV_W       = 6,
    parameter int INV_INIT    = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [AMT_W-1:0] amount,
    output logic [2:0]       coin_req,
    input  logic             coin_ack,
    input  logic             restock,
    output logic             busy,
    output logic             done,
    output logic [AMT_W-1:0] shortfall,
    output logic             fault
);

    localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);

    change_state_t    state, state_nxt;
    logic [AMT_W-1:0] remaining, remaining_nxt;
    logic [AMT_W-1:0] shortfall_q, shortfall_nxt;
    logic [TMR_W-1:0] timer, timer_nxt;
    coin_sel_t        coin_sel_q, coin_sel_nxt;
    logic [AMT_W-1:0] coin_val_q, coin_val_nxt;
    logic             take_coin;

    coin_sel_t        pick_sel;
    logic [AMT_W-1:0] pick_val;
    logic [2:0]       avail;

    change_coin_select #(.AMT_W(AMT_W)) u_select (
        .remaining (remaining),
        .avail     (avail),
        .sel       (pick_sel),
        .value     (pick_val)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; the async reset branch comes first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= CHG_IDLE;
            remaining   <= '0;
            shortfall_q <= '0;
            timer       <= '0;
            coin_sel_q  <= COIN_NONE;
            coin_val_q  <= '0;
        end else begin
            state       <= state_nxt;
            remaining   <= remaining_nxt;
            shortfall_q <= shortfall_nxt;
            timer       <= timer_nxt;
            coin_sel_q  <= coin_sel_nxt;
            coin_val_q  <= coin_val_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        shortfall_nxt = shortfall_q;
        timer_nxt     = timer;
        coin_sel_nxt  = coin_sel_q;
        coin_val_nxt  = coin_val_q;
        take_coin     = 1'b0;

        unique case (state)
            CHG_IDLE: begin
                if (start) begin
                    remaining_nxt = amount;
                    shortfall_nxt = '0;
                    state_nxt     = CHG_SELECT;
                end
            end
            CHG_SELECT: begin
                // The choice is latched so a restock during REQUEST cannot
                // change the coin already being requested.
                if (pick_sel != COIN_NONE) begin
                    coin_sel_nxt = pick_sel;
                    coin_val_nxt = pick_val;
                    timer_nxt    = '0;
                    state_nxt    = CHG_REQUEST;
                end else begin
                    shortfall_nxt = remaining;
                    state_nxt     = CHG_DONE;
                end
            end
            CHG_REQUEST: begin
                if (coin_ack) begin
                    remaining_nxt = remaining - coin_val_q;
                    take_coin     = 1'b1;
                    state_nxt     = CHG_RELEASE;
                end else if (timer == TMR_W'(ACK_TIMEOUT - 1)) begin
                    state_nxt = CHG_FAULT;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            CHG_RELEASE: begin
                if (!coin_ack) begin
                    state_nxt = CHG_SELECT;
                end
            end
            CHG_DONE:  state_nxt = CHG_IDLE;
            CHG_FAULT: state_nxt = CHG_FAULT;
            default:   state_nxt = CHG_IDLE;
        endcase
    end

    // Outputs decode straight from registered state, so reset clears them at once.
    assign coin_req  = (state == CHG_REQUEST) ? coin_sel_q : 3'b000;
    assign busy      = (state != CHG_IDLE);
    assign done      = (state == CHG_DONE);
    assign fault     = (state == CHG_FAULT);
    assign shortfall = shortfall_q;

`ifdef CHANGE_INVENTORY_EN
    logic [2:0] held_bits;
    assign held_bits = coin_sel_q;

    for (genvar i = 0; i < 3; i++) begin : g_inv
        logic [INV_W-1:0] count;

        // Restock takes priority over a same-cycle payout decrement.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                count <= INV_W'(INV_INIT);
            end else if (restock) begin
                count <= INV_W'(INV_INIT);
            end else if (take_coin && held_bits[i] && (count != '0)) begin
                count <= count - 1'b1;
            end
        end

        assign avail[i] = (count != '0);
    end
`else
    localparam int inv_cfg_unused = INV_W + INV_INIT;
    logic inv_unused;
    assign inv_unused = restock | take_coin;
    assign avail      = 3'b111;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Directed self-checking bench for change_dispenser; the inventory sequence runs
// only when CHANGE_INVENTORY_EN is defined.
module tb_change_dispenser;

    localparam int ACK_TIMEOUT = 255;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] amount;
    logic [2:0] coin_req;
    logic       coin_ack;
    logic       restock;
    logic       busy;
    logic       done;
    logic [7:0] shortfall;
    logic       fault;

    change_dispenser #(
        .AMT_W       (8),
        .ACK_TIMEOUT (ACK_TIMEOUT),
        .INV_W       (6),
        .INV_INIT    (20)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .amount    (amount),
        .coin_req  (coin_req),
        .coin_ack  (coin_ack),
        .restock   (restock),
        .busy      (busy),
        .done      (done),
        .shortfall (shortfall),
        .fault     (fault)
    );

    int total = 0;
    int bad   = 0;

    // Hopper model / monitor state (written only by the hopper process).
    bit         hopper_on = 1'b1;
    logic [2:0] prev_req  = 3'b000;
    int         mon_n25 = 0, mon_n10 = 0, mon_n5 = 0;
    int         mon_multi = 0, mon_order = 0, mon_last = 255;

    typedef struct {
        logic [7:0] amt;
        int         n25;
        int         n10;
        int         n5;
        logic [7:0] sf;
    } vec_t;

    vec_t vecs [10];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hopper: acks one cycle after seeing a request, drops ack once req drops.
    initial begin
        coin_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if ($countones(coin_req) > 1) mon_multi++;
            if ((coin_req != 3'b000) && (prev_req == 3'b000)) begin
                int val;
                val = 0;
                case (coin_req)
                    3'b100:  begin mon_n25++; val = 25; end
                    3'b010:  begin mon_n10++; val = 10; end
                    3'b001:  begin mon_n5++;  val = 5;  end
                    default: val = 0;
                endcase
                if (val > mon_last) mon_order++;
                mon_last = val;
            end
            if ((coin_req == 3'b000) && !busy) mon_last = 255;
            coin_ack = hopper_on && (coin_req != 3'b000) && (prev_req != 3'b000);
            prev_req = coin_req;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_payout(input logic [7:0] amt, input int e25, input int e10,
                              input int e5, input logic [7:0] esf, input string tag);
        int b25, b10, b5, bmulti, border, lat;
        bit seen;
        b25 = mon_n25; b10 = mon_n10; b5 = mon_n5;
        bmulti = mon_multi; border = mon_order;
        amount = amt;
        start  = 1'b1;
        lat    = 0;
        seen   = 1'b0;
        for (int c = 0; c < 400; c++) begin
            tick();
            lat++;
            if (lat == 1) begin
                start = 1'b0;
                check({tag, ".sf_clear"}, 32'(shortfall), 32'd0);
                check({tag, ".busy_on"}, 32'(busy), 32'd1);
            end
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, ".done_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            check({tag, ".latency"}, 32'(lat), 32'(2 + 4 * (e25 + e10 + e5)));
            check({tag, ".busy_at_done"}, 32'(busy), 32'd1);
            check({tag, ".shortfall"}, 32'(shortfall), 32'(esf));
            check({tag, ".n25"}, 32'(mon_n25 - b25), 32'(e25));
            check({tag, ".n10"}, 32'(mon_n10 - b10), 32'(e10));
            check({tag, ".n5"}, 32'(mon_n5 - b5), 32'(e5));
            check({tag, ".onehot"}, 32'(mon_multi - bmulti), 32'd0);
            check({tag, ".order"}, 32'(mon_order - border), 32'd0);
            tick();
            check({tag, ".done_pulse"}, 32'(done), 32'd0);
            check({tag, ".busy_off"}, 32'(busy), 32'd0);
            check({tag, ".sf_hold"}, 32'(shortfall), 32'(esf));
        end
    endtask

    task automatic wait_req(input string tag);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 50; c++) begin
            tick();
            start = 1'b0;
            if (coin_req != 3'b000) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, ".req_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        amount  = 8'd0;
        restock = 1'b0;

        vecs[0] = '{8'd40,  1,  1, 1, 8'd0};
        vecs[1] = '{8'd0,   0,  0, 0, 8'd0};
        vecs[2] = '{8'd7,   0,  0, 1, 8'd2};
        vecs[3] = '{8'd35,  1,  1, 0, 8'd0};
        vecs[4] = '{8'd255, 10, 0, 1, 8'd0};
        vecs[5] = '{8'd19,  0,  1, 1, 8'd4};
        vecs[6] = '{8'd3,   0,  0, 0, 8'd3};
        vecs[7] = '{8'd60,  2,  1, 0, 8'd0};
        vecs[8] = '{8'd9,   0,  0, 1, 8'd4};
        vecs[9] = '{8'd30,  1,  0, 1, 8'd0};

        tick();
        tick();
        check("rst.coin_req", 32'(coin_req), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.shortfall", 32'(shortfall), 32'd0);
        check("rst.fault", 32'(fault), 32'd0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) begin
            run_payout(vecs[i].amt, vecs[i].n25, vecs[i].n10, vecs[i].n5,
                       vecs[i].sf, $sformatf("vec%0d_amt%0d", i, vecs[i].amt));
        end

`ifdef CHANGE_INVENTORY_EN
        restock = 1'b1;
        tick();
        restock = 1'b0;
        run_payout(8'd225, 9,  0, 0, 8'd0, "inv_drain_a");
        run_payout(8'd250, 10, 0, 0, 8'd0, "inv_drain_b");
        run_payout(8'd50,  1,  2, 1, 8'd0, "inv_last25");
        run_payout(8'd25,  0,  2, 1, 8'd0, "inv_empty25");
        restock = 1'b1;
        tick();
        restock = 1'b0;
        run_payout(8'd25,  1,  0, 0, 8'd0, "inv_restocked");
`endif

        // Start mid-payout is ignored, then reset mid-REQUEST drops coin_req at once.
        hopper_on = 1'b0;
        amount    = 8'd25;
        start     = 1'b1;
        wait_req("midrst");
        check("midrst.req", 32'(coin_req), 32'b100);
        amount = 8'd5;
        start  = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("midrst.req_after_start", 32'(coin_req), 32'b100);
        check("midrst.busy", 32'(busy), 32'd1);
        #3;
        reset = 1'b1;
        #1;
        check("midrst.req_async", 32'(coin_req), 32'd0);
        check("midrst.busy_async", 32'(busy), 32'd0);
        check("midrst.fault_async", 32'(fault), 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // Ack never comes: fault exactly ACK_TIMEOUT cycles after the request rises.
        amount = 8'd5;
        start  = 1'b1;
        wait_req("tmo");
        begin
            int  k;
            bit  seen;
            logic [2:0] last_req;
            k        = 0;
            seen     = 1'b0;
            last_req = coin_req;
            for (int c = 0; c < 600; c++) begin
                tick();
                k++;
                if (fault) begin
                    seen = 1'b1;
                    break;
                end
                last_req = coin_req;
            end
            check("tmo.fault_seen", 32'(seen), 32'd1);
            check("tmo.cycles", 32'(k), 32'(ACK_TIMEOUT));
            check("tmo.req_before", 32'(last_req), 32'b001);
            check("tmo.req_dropped", 32'(coin_req), 32'd0);
        end
        begin
            int done_cnt, req_cnt, lost;
            done_cnt = 0;
            req_cnt  = 0;
            lost     = 0;
            amount   = 8'd40;
            start    = 1'b1;
            for (int c = 0; c < 12; c++) begin
                tick();
                start = 1'b0;
                if (done) done_cnt++;
                if (coin_req != 3'b000) req_cnt++;
                if (!fault || !busy) lost++;
            end
            check("tmo.no_done", 32'(done_cnt), 32'd0);
            check("tmo.no_req", 32'(req_cnt), 32'd0);
            check("tmo.sticky", 32'(lost), 32'd0);
        end

        hopper_on = 1'b1;
        do_reset();
        check("post_fault.fault", 32'(fault), 32'd0);
        check("post_fault.busy", 32'(busy), 32'd0);
        run_payout(8'd40, 1, 1, 1, 8'd0, "post_fault");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
